// File: rtl/stage_if.sv
// Instruction-fetch stage.
//
// Issues one instruction-SRAM read per cycle whenever the stage can accept a
// new instruction, and presents the fetched word to decode one cycle later.
// A redirect from decode cancels the in-flight wrong-path instruction. If
// decode is stalled at that moment, the target is remembered and fetched on
// the following cycle. While decode stalls, the returned word is latched into
// a one-entry buffer, so the output stays stable even if the SRAM read port
// changes underneath it.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   allowout          decode can accept an instruction this cycle
//   validout          output_pc/output_inst hold a valid instruction
//   br_taken          decode-stage redirect (already qualified)
//   br_target         redirect address
//   output_pc         PC of the held instruction
//   output_inst       held instruction word
//   inst_sram_*       instruction SRAM request/response (read only)
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        allowout,
  output logic        validout,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] output_pc,
  output logic [31:0] output_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        ibuf_valid_q, ibuf_valid_d;
  logic [31:0] ibuf_q, ibuf_d;

  logic        readygo;
  logic        allowin;
  logic [31:0] nextpc;

  // Fetch always completes in one cycle.
  assign readygo = 1'b1;
  assign allowin = ~valid_q | (readygo & allowout);

  // A fresh redirect beats a remembered one; pc+4 wraps naturally at 2^32.
  always_comb begin
    if (br_taken) begin
      nextpc = br_target;
    end else if (redir_pend_q) begin
      nextpc = redir_pc_q;
    end else begin
      nextpc = pc_q + 32'd4;
    end
  end

  assign inst_sram_en    = allowin & ~rst;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // A redirect in the current cycle means the held instruction is wrong-path.
  assign validout    = valid_q & ~br_taken & ~rst;
  assign output_pc   = pc_q;
  assign output_inst = ibuf_valid_q ? ibuf_q : inst_sram_rdata;

  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    ibuf_valid_d = ibuf_valid_q;
    ibuf_d       = ibuf_q;
    if (allowin) begin
      pc_d         = nextpc;
      valid_d      = 1'b1;
      redir_pend_d = 1'b0;
      ibuf_valid_d = 1'b0;
    end else if (br_taken) begin
      // Stalled redirect: drop the held instruction, fetch target next cycle.
      valid_d      = 1'b0;
      redir_pend_d = 1'b1;
      redir_pc_d   = br_target;
    end else if (!ibuf_valid_q) begin
      // Stalled with a valid instruction: latch the word before the SRAM
      // read port is allowed to change.
      ibuf_d       = inst_sram_rdata;
      ibuf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC - 32'd4;
      valid_q      <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      ibuf_valid_q <= 1'b0;
      ibuf_q       <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_q       <= ibuf_d;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed testbench for stage_if with a one-cycle-latency instruction SRAM.
module tb_stage_if;

  logic        clk;
  logic        rst;
  logic        allowout;
  logic        validout;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] output_pc;
  logic [31:0] output_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic [31:0] mem_q;
  logic        corrupt;

  int n_cmp;
  int n_err;

  stage_if #(
    .RESET_PC(32'h1C00_0000)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .allowout       (allowout),
    .validout       (validout),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .output_pc      (output_pc),
    .output_inst    (output_inst),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at each address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) mem_q <= inst_of(inst_sram_addr);
  end
  assign inst_sram_rdata = corrupt ? 32'hDEAD_BEEF : mem_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; checks follow 1ns later.
  task automatic cyc(input logic r, input logic ao, input logic bt, input logic [31:0] tgt);
    @(negedge clk);
    rst       = r;
    allowout  = ao;
    br_taken  = bt;
    br_target = tgt;
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    corrupt   = 1'b0;
    mem_q     = 32'h0;
    rst       = 1'b1;
    allowout  = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'h0;

    // Reset
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("rst_validout", validout, 0);
    check("rst_en", inst_sram_en, 0);
    check("rst_we", inst_sram_we, 0);
    check("rst_wdata", inst_sram_wdata, 0);

    // First cycles after reset, decode always ready
    cyc(0, 1, 0, 0);
    check("a_en", inst_sram_en, 1);
    check("a_addr", inst_sram_addr, 32'h1C00_0000);
    check("a_validout", validout, 0);
    check("a_pc", output_pc, 32'h1BFF_FFFC);
    cyc(0, 1, 0, 0);
    check("b_addr", inst_sram_addr, 32'h1C00_0004);
    check("b_validout", validout, 1);
    check("b_pc", output_pc, 32'h1C00_0000);
    check("b_inst", output_inst, inst_of(32'h1C00_0000));

    // Decode stalls three cycles holding 1C000004; SRAM output corrupted
    cyc(0, 0, 0, 0);
    check("c_en", inst_sram_en, 0);
    check("c_validout", validout, 1);
    check("c_pc", output_pc, 32'h1C00_0004);
    check("c_inst", output_inst, inst_of(32'h1C00_0004));
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0);
      corrupt = 1'b1;
      #1;
      check("stall_en", inst_sram_en, 0);
      check("stall_pc", output_pc, 32'h1C00_0004);
      check("stall_inst", output_inst, inst_of(32'h1C00_0004));
    end
    cyc(0, 1, 0, 0);
    check("f_en", inst_sram_en, 1);
    check("f_addr", inst_sram_addr, 32'h1C00_0008);
    check("f_inst", output_inst, inst_of(32'h1C00_0004));
    @(posedge clk);
    #1;
    corrupt = 1'b0;

    // Redirect while flowing
    cyc(0, 1, 1, 32'h1C00_0100);
    check("g_validout", validout, 0);
    check("g_addr", inst_sram_addr, 32'h1C00_0100);
    cyc(0, 1, 0, 0);
    check("h_validout", validout, 1);
    check("h_pc", output_pc, 32'h1C00_0100);
    check("h_inst", output_inst, inst_of(32'h1C00_0100));
    check("h_addr", inst_sram_addr, 32'h1C00_0104);

    // Redirect while stalled: cancel cycle then fetch cycle
    cyc(0, 0, 1, 32'h1C00_0200);
    check("i_validout", validout, 0);
    check("i_en", inst_sram_en, 0);
    cyc(0, 0, 0, 0);
    check("j_validout", validout, 0);
    check("j_en", inst_sram_en, 1);
    check("j_addr", inst_sram_addr, 32'h1C00_0200);
    cyc(0, 1, 0, 0);
    check("k_validout", validout, 1);
    check("k_pc", output_pc, 32'h1C00_0200);
    check("k_inst", output_inst, inst_of(32'h1C00_0200));

    // Two redirects in consecutive stalled cycles; the later one wins
    cyc(0, 0, 1, 32'h1C00_0300);
    check("l_validout", validout, 0);
    cyc(0, 0, 1, 32'h1C00_0400);
    check("m_validout", validout, 0);
    check("m_en", inst_sram_en, 1);
    check("m_addr", inst_sram_addr, 32'h1C00_0400);
    cyc(0, 1, 0, 0);
    check("n_validout", validout, 1);
    check("n_pc", output_pc, 32'h1C00_0400);
    check("n_addr", inst_sram_addr, 32'h1C00_0404);

    // PC wraps at the top of the address space
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    check("o_addr", inst_sram_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0);
    check("p_pc", output_pc, 32'hFFFF_FFFC);
    check("p_addr", inst_sram_addr, 32'h0000_0000);
    cyc(0, 1, 0, 0);
    check("q_pc", output_pc, 32'h0000_0000);
    check("q_inst", output_inst, inst_of(32'h0000_0000));

    // Reset with a pending redirect: it must be discarded
    cyc(0, 0, 1, 32'h1C00_0500);
    cyc(1, 1, 0, 0);
    check("s_validout", validout, 0);
    check("s_en", inst_sram_en, 0);
    cyc(0, 1, 0, 0);
    check("t_addr", inst_sram_addr, 32'h1C00_0000);
    check("t_validout", validout, 0);
    cyc(0, 1, 0, 0);
    check("u_validout", validout, 1);
    check("u_pc", output_pc, 32'h1C00_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C000000, meaning the address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port allowout  input  1  decode stage can accept an instruction this cycle.
REQ-005 SHALL have port validout  output  1  output_pc/output_inst hold a valid instruction.
REQ-006 SHALL have port br_taken  input  1  decode-stage redirect, already qualified by decode valid/stall.
REQ-007 SHALL have port br_target  input  32  redirect address.
REQ-008 SHALL have port output_pc  output  32  PC of the held instruction.
REQ-009 SHALL have port output_inst  output  32  held instruction word.
REQ-010 SHALL have port inst_sram_en  output  1  fetch request.
REQ-011 SHALL have port inst_sram_we  output  4  tied to 4'h0.
REQ-012 SHALL have port inst_sram_addr  output  32  fetch address.
REQ-013 SHALL have port inst_sram_wdata  output  32  tied to 32'h0.
REQ-014 SHALL have port inst_sram_rdata  input  32  read data, valid the cycle after an enabled request, held stable while en=0.

Function
REQ-015 SHALL keep registers pc (32), valid (1), redir_pend (1), redir_pc (32), ibuf_valid (1), ibuf (32).
REQ-016 SHALL drive readygo=1 and allowin = ~valid | allowout.
REQ-017 SHALL compute nextpc with priority: br_taken -> br_target; else redir_pend -> redir_pc; else pc+4, with wrap modulo 2^32.
REQ-018 SHALL drive inst_sram_en = allowin & ~rst, and inst_sram_addr = nextpc.
REQ-019 SHALL, when allowin & ~rst, load pc<=nextpc, set valid<=1, clear redir_pend, and clear ibuf_valid.
REQ-020 SHALL drive validout = valid & ~br_taken, discarding the wrong-path instruction in the cycle a redirect arrives.
REQ-021 SHALL, when br_taken & ~allowin, set valid<=0, redir_pend<=1, and redir_pc<=br_target; pc is unchanged.
REQ-022 SHALL give a later br_taken priority over an older redir_pend, overwriting redir_pc.
REQ-023 SHALL, when valid & ~allowout & ~ibuf_valid & ~br_taken, capture ibuf<=inst_sram_rdata and set ibuf_valid<=1.
REQ-024 SHALL drive output_inst = ibuf_valid ? ibuf : inst_sram_rdata, and output_pc = pc.
REQ-025 SHALL have a fetch-to-validout latency of exactly 1 cycle, with no bubbles in sustained flow.
REQ-026 SHALL have a redirect penalty of 1 cycle when allowin, and 2 cycles when stalled (cancel cycle plus fetch cycle).
REQ-027 SHALL hold output_pc/output_inst stable while validout & ~allowout.

Reset
REQ-028 SHALL, while rst, set pc<=RESET_PC-4, valid<=0, redir_pend<=0, redir_pc<=0, ibuf_valid<=0, and ibuf<=0.
REQ-029 SHALL keep validout=0 and inst_sram_en=0 during rst.
REQ-030 SHALL issue the first request on the first cycle after rst deasserts, with addr RESET_PC.
REQ-031 SHALL discard any pending redirect or buffered instruction when rst is asserted mid-operation.

Verification
REQ-032 SHALL cover reset release with allowout=1: addr sequence 1C000000, 1C000004, 1C000008; validout=1 from cycle 2, with output_pc lagging addr by 1 cycle.
REQ-033 SHALL cover allowout=0 for 3 cycles with output_pc=1C000004: inst_sram_en=0, outputs frozen even if rdata is corrupted by the bench, and the next addr after release is 1C000008.
REQ-034 SHALL cover br_taken=1 with target 1C000100 and allowout=1: validout=0 that cycle, addr=1C000100, and next output_pc=1C000100.
REQ-035 SHALL cover br_taken with target 1C000200 while allowout=0: valid drops, the next cycle addr=1C000200, and no wrong-path instruction ever has validout=1.
REQ-036 SHALL cover two redirects in consecutive stalled cycles (1C000300, then 1C000400): the fetch goes to 1C000400.
REQ-037 SHALL cover pc=FFFFFFFC with no branch: next addr=00000000.
